// File: rtl/ctrl_ex_dm_core.sv
// ctrl_ex_dm_core: ID-stage control decode, EX-stage ALU and branch target,
// and MEM-stage word-addressed data memory of the MIPS-subset pipeline.
// Optional feature macro: CU_ADDI_EN (adds decode of opcode 001000, addi).
module ctrl_ex_dm_core #(
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_flag_in,
    output logic        stall_flag_out,
    input  logic [5:0]  opcode,
    output logic        reg_dst,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUOp,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] sign_ext,
    input  logic [31:0] pc,
    output logic [31:0] resultOut,
    output logic        zero,
    output logic [31:0] address,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic [31:0] Mem_address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_Data
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CU_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [31:0]   mem [DMEM_DEPTH];
    logic [AW-1:0] mem_idx;
    logic [31:0]   alu_b;
    logic [31:0]   alu_result;
    logic [31:0]   branch_target;
    logic [5:0]    funct;
    logic          unused_addr_bits;

    assign mem_idx          = Mem_address[AW+1:2];
    assign funct            = sign_ext[5:0];
    assign branch_target    = pc + (sign_ext << 2);
    assign unused_addr_bits = ^{Mem_address[31:AW+2], Mem_address[1:0]};

    // Opcode decode; bubbles (stall or reset) force every control low.
    always_comb begin
        reg_dst    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        if (!reset && !stall_flag_in) begin
            case (opcode)
                OP_RTYPE: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = 2'b10;
                end
                OP_LW: begin
                    alu_src    = 1'b1;
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                OP_SW: begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
                OP_BEQ: begin
                    branch = 1'b1;
                    alu_op = 2'b01;
                end
`ifdef CU_ADDI_EN
                OP_ADDI: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // ALU: operand select, then class/funct dispatch (wraps mod 2^32).
    always_comb begin
        alu_b      = ALUSrc ? sign_ext : rt;
        alu_result = '0;
        case (ALUOp)
            2'b00: alu_result = rs + alu_b;
            2'b01: alu_result = rs - alu_b;
            2'b10: begin
                case (funct)
                    FN_ADD:  alu_result = rs + alu_b;
                    FN_SUB:  alu_result = rs - alu_b;
                    FN_AND:  alu_result = rs & alu_b;
                    FN_OR:   alu_result = rs | alu_b;
                    FN_SLT:  alu_result = 32'($signed(rs) < $signed(alu_b));
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // EX/MEM result registers; reset wins, stall freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            resultOut      <= '0;
            zero           <= 1'b1;
            address        <= '0;
            Read_Data      <= '0;
            stall_flag_out <= 1'b0;
        end else begin
            stall_flag_out <= stall_flag_in;
            if (!stall_flag_in) begin
                resultOut <= alu_result;
                zero      <= (alu_result == 32'd0);
                address   <= branch_target;
                if (Mem_read) begin
                    Read_Data <= mem[mem_idx];
                end
            end
        end
    end

    // Data memory array: cleared on reset, written only when not stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Mem_write && !stall_flag_in) begin
            mem[mem_idx] <= Write_data;
        end
    end

endmodule

// File: tb/tb_ctrl_ex_dm_core.sv
// Directed self-checking bench for ctrl_ex_dm_core.
module tb_ctrl_ex_dm_core;

    localparam int unsigned DMEM_DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_flag_in;
    logic        stall_flag_out;
    logic [5:0]  opcode;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic        ALUSrc;
    logic [1:0]  ALUOp;
    logic [31:0] rs, rt, sign_ext, pc;
    logic [31:0] resultOut;
    logic        zero;
    logic [31:0] address;
    logic        Mem_read, Mem_write;
    logic [31:0] Mem_address, Write_data;
    logic [31:0] Read_Data;

    int vectors = 0;
    int miscompares = 0;

    ctrl_ex_dm_core #(.DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .stall_flag_in(stall_flag_in), .stall_flag_out(stall_flag_out),
        .opcode(opcode),
        .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .alu_op(alu_op),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .rs(rs), .rt(rt),
        .sign_ext(sign_ext), .pc(pc),
        .resultOut(resultOut), .zero(zero), .address(address),
        .Mem_read(Mem_read), .Mem_write(Mem_write),
        .Mem_address(Mem_address), .Write_data(Write_data),
        .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctl_vec();
        return {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_flag_in = 1'b0; opcode = 6'b000000;
        ALUSrc = 1'b0; ALUOp = 2'b00; rs = '0; rt = '0; sign_ext = '0; pc = '0;
        Mem_read = 1'b0; Mem_write = 1'b0; Mem_address = '0; Write_data = '0;
        tick();
        tick();
        vectors++;
        if (ctl_vec() !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected %b", ctl_vec(), 9'd0);
        end
        reset = 1'b0;
        #1;
        chk32("reset_result", resultOut, 32'h0);
        chk32("reset_zero", 32'(zero), 32'h1);
        chk32("reset_address", address, 32'h0);
        chk32("reset_read_data", Read_Data, 32'h0);
        chk32("reset_stall_out", 32'(stall_flag_out), 32'h0);
        Mem_read = 1'b1; Mem_address = 32'h10;
        tick();
        Mem_read = 1'b0;
        chk32("reset_load_0x10", Read_Data, 32'h0);
    endtask

    task automatic test_decode();
        logic [5:0] ops [6];
        logic [8:0] exp [6];
        ops[0] = 6'b000000; exp[0] = 9'b1_0_0_0_0_0_1_10;
        ops[1] = 6'b100011; exp[1] = 9'b0_0_1_1_0_1_1_00;
        ops[2] = 6'b101011; exp[2] = 9'b0_0_0_0_1_1_0_00;
        ops[3] = 6'b000100; exp[3] = 9'b0_1_0_0_0_0_0_01;
        ops[4] = 6'b111111; exp[4] = 9'b0;
        ops[5] = 6'b001000;
`ifdef CU_ADDI_EN
        exp[5] = 9'b0_0_0_0_0_1_1_00;
`else
        exp[5] = 9'b0;
`endif
        for (int s = 0; s < 2; s++) begin
            stall_flag_in = (s == 1);
            for (int i = 0; i < 6; i++) begin
                opcode = ops[i];
                #1;
                vectors++;
                if (ctl_vec() !== ((s == 1) ? 9'd0 : exp[i])) begin
                    miscompares++;
                    $display("FAIL decode op=%b stall=%0d: got %b expected %b",
                             ops[i], s, ctl_vec(), (s == 1) ? 9'd0 : exp[i]);
                end
            end
        end
        stall_flag_in = 1'b0;
        opcode = 6'b000000;
    endtask

    task automatic test_alu();
        logic [5:0]  fn   [5];
        logic [31:0] want [5];
        fn[0] = 6'b100000; want[0] = 32'd12;
        fn[1] = 6'b100010; want[1] = 32'd2;
        fn[2] = 6'b100100; want[2] = 32'd5;
        fn[3] = 6'b100101; want[3] = 32'd7;
        fn[4] = 6'b101010; want[4] = 32'd0;
        ALUOp = 2'b10; ALUSrc = 1'b0; rs = 32'd7; rt = 32'd5; pc = '0;
        for (int i = 0; i < 5; i++) begin
            sign_ext = {26'd0, fn[i]};
            tick();
            chk32($sformatf("alu_rtype_fn%b", fn[i]), resultOut, want[i]);
        end
        chk32("alu_slt0_zero", 32'(zero), 32'h1);
        rs = 32'hFFFF_FFFF; rt = 32'd1;
        tick();
        chk32("alu_slt_neg", resultOut, 32'd1);
        chk32("alu_slt_neg_zero", 32'(zero), 32'h0);
        sign_ext = {26'd0, 6'b100010};
        tick();
        chk32("alu_sub_neg", resultOut, 32'hFFFF_FFFE);
        ALUOp = 2'b00; ALUSrc = 1'b1; rs = 32'd10; sign_ext = 32'hFFFF_FFFD;
        tick();
        chk32("alu_add_imm", resultOut, 32'd7);
        ALUOp = 2'b11;
        tick();
        chk32("alu_op11", resultOut, 32'd0);
        ALUOp = 2'b10; ALUSrc = 1'b0; sign_ext = 32'h0000_002A;
        tick();
    endtask

    task automatic test_branch();
        ALUOp = 2'b01; ALUSrc = 1'b0; rs = 32'd9; rt = 32'd9; pc = 32'h100; sign_ext = 32'd3;
        #1;
        chk32("branch_addr_before_edge", address, 32'h0000_00A8);
        tick();
        chk32("branch_zero", 32'(zero), 32'h1);
        chk32("branch_result", resultOut, 32'h0);
        chk32("branch_address", address, 32'h10C);
        pc = 32'h200; sign_ext = 32'hFFFF_FFFF;
        tick();
        chk32("branch_back_address", address, 32'h1FC);
    endtask

    task automatic test_memory();
        Mem_write = 1'b1; Mem_address = 32'h20; Write_data = 32'hDEAD_BEEF;
        tick();
        Mem_write = 1'b0; Mem_read = 1'b1;
        tick();
        chk32("mem_load", Read_Data, 32'hDEAD_BEEF);
        Mem_address = 32'h20 + 4 * DMEM_DEPTH;
        Mem_write = 1'b1; Write_data = 32'h0; Mem_write = 1'b0;
        tick();
        chk32("mem_load_wrap", Read_Data, 32'hDEAD_BEEF);
        Mem_read = 1'b0; Mem_address = 32'h24;
        tick();
        chk32("mem_hold", Read_Data, 32'hDEAD_BEEF);
        // stalled store and ALU freeze
        stall_flag_in = 1'b1; Mem_write = 1'b1; Mem_address = 32'h20; Write_data = 32'h1234_5678;
        ALUOp = 2'b00; rs = 32'd100; rt = 32'd1;
        tick();
        chk32("stall_out_set", 32'(stall_flag_out), 32'h1);
        chk32("stall_result_hold", resultOut, 32'h0);
        chk32("stall_address_hold", address, 32'h1FC);
        stall_flag_in = 1'b0; Mem_write = 1'b0; Mem_read = 1'b1; Mem_address = 32'h23;
        tick();
        chk32("stall_store_blocked", Read_Data, 32'hDEAD_BEEF);
        chk32("stall_out_clear", 32'(stall_flag_out), 32'h0);
        chk32("post_stall_result", resultOut, 32'd101);
        // read-before-write
        Mem_write = 1'b1; Write_data = 32'hCAFE_F00D;
        tick();
        chk32("rbw_old", Read_Data, 32'hDEAD_BEEF);
        Mem_write = 1'b0;
        tick();
        chk32("rbw_new", Read_Data, 32'hCAFE_F00D);
        Mem_read = 1'b0;
    endtask

    task automatic test_reset_discard();
        reset = 1'b1; Mem_write = 1'b1; Mem_address = 32'h24; Write_data = 32'h5555_5555;
        tick();
        reset = 1'b0; Mem_write = 1'b0; Mem_read = 1'b1;
        tick();
        chk32("reset_store_discard", Read_Data, 32'h0);
        Mem_address = 32'h20;
        tick();
        chk32("reset_mem_cleared", Read_Data, 32'h0);
        Mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alu();
        test_branch();
        test_memory();
        test_reset_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_ex_dm_core.md
# ctrl_ex_dm_core

Combined control-decode, execute and data-memory core of the 5-stage MIPS-subset pipeline. It decodes the ID-stage opcode into datapath control signals. It performs the EX-stage ALU operation and branch-target computation, and services MEM-stage loads and stores from a word-addressed data memory. Inter-stage registers (ID/EX, EX/DM, DM/WB) sit outside this block.

## Interface
- DMEM_DEPTH, 256: data-memory words; power of two.
- Clocking: one clock `clk`; `reset` is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall_flag_in  in  1  pipeline stall request
- stall_flag_out  out  1  stall_flag_in delayed one cycle
- opcode  in  6  ID-stage instruction[31:26]
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  decoded controls
- alu_op  out  2  decoded ALU class
- ALUSrc  in  1  EX: select sign_ext as operand B
- ALUOp  in  2  EX: ALU class
- rs, rt  in  32  EX: register operands
- sign_ext  in  32  EX: sign-extended immediate; [5:0] is funct
- pc  in  32  EX: PC+4 of the instruction
- resultOut  out  32  registered ALU result
- zero  out  1  registered (ALU result == 0)
- address  out  32  registered branch target
- Mem_read, Mem_write  in  1  MEM: load/store enables
- Mem_address  in  32  MEM: byte address
- Write_data  in  32  MEM: store data
- Read_Data  out  32  registered load data

## Operation
- Decode is combinational. Unlisted opcodes and stall_flag_in=1 give all controls 0.
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
- ALU operand A is rs; operand B is sign_ext if ALUSrc=1, else rt.
- ALU function by ALUOp:
  - 00: add.
  - 01: subtract.
  - 10: by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed; result 1/0).
  - Other funct values and ALUOp=11: result 0.
- All arithmetic is 32-bit modulo 2^32; overflow is ignored.
- address = pc + (sign_ext << 2), modulo 2^32.
- Data memory is word addressed by Mem_address[log2(DMEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap. Bits [1:0] are ignored.
- Store: on a rising edge with Mem_write=1, the addressed word is written.
- Load: on a rising edge with Mem_read=1, Read_Data takes the addressed word. Read_Data holds otherwise.
- Simultaneous Mem_read and Mem_write to the same word: Read_Data returns the old contents (read-before-write).
- Stall: while stall_flag_in=1, resultOut/zero/address/Read_Data hold their values and the memory is not written.

## Timing
- Control outputs: 0 cycles (combinational from opcode and stall_flag_in).
- resultOut, zero, address, Read_Data: 1-cycle latency, updated on rising clk.
- stall_flag_out: 1-cycle latency.
- Reset, on a rising edge with reset=1:
  - resultOut, address, Read_Data = 0; zero = 1; stall_flag_out = 0.
  - All memory words = 0.
  - Reset takes priority over store, load and stall.
- Asserting reset mid-operation discards any store issued in the same cycle.
- Control outputs are 0 while reset=1.

## Configuration
- CU_ADDI_EN defined: opcode 001000 (addi) decodes to alu_src=1, reg_write=1, alu_op=00, all other controls 0.
- CU_ADDI_EN undefined: 001000 is an unlisted opcode and gives all controls 0.

## Test plan
- Reset: hold reset for 2 cycles, then release. Required: resultOut=0, zero=1, address=0, Read_Data=0, stall_flag_out=0, and a load from address 0x10 returns 0.
- Decode sweep: opcodes 000000, 100011, 101011, 000100, 111111 give the listed controls; the same sweep with stall_flag_in=1 gives all zeros.
- ALU, R-type: ALUOp=10, rs=7, rt=5, with funct 100000/100010/100100/100101/101010. Required resultOut = 12/2/5/7/0. Repeat with rs=-1, rt=1: slt gives 1.
- Branch: ALUOp=01, rs=rt=9, pc=0x100, sign_ext=3. Required: zero=1, resultOut=0, address=0x10C, one cycle after the inputs.
- Memory: store 0xDEADBEEF to address 0x20, then load 0x20 (Read_Data=0xDEADBEEF next cycle). Load 0x20+4·DMEM_DEPTH (same word, wrap). A store with stall_flag_in=1 leaves memory unchanged.
- Build with and without CU_ADDI_EN. Required: opcode 001000 yields alu_src=1, reg_write=1 when the macro is defined, and all controls 0 when it is not.
